// File: rtl/vram_arbiter_if.sv
// Bundle of the CPU, video and RAM-side signals of the video RAM arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
);
  logic              cpuReq;
  logic              cpuWe;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWdata;
  logic [DATA_W-1:0] cpuRdata;
  logic              cpuAck;
  logic              cpuWait;

  logic              vidReq;
  logic [ADDR_W-1:0] vidAddr;
  logic [DATA_W-1:0] vidRdata;
  logic              vidAck;

  logic              ramCs;
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata;
  logic [DATA_W-1:0] ramRdata;

  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWdata,
    output cpuRdata, cpuAck, cpuWait,
    input  vidReq, vidAddr,
    output vidRdata, vidAck,
    output ramCs, ramWe, ramAddr, ramWdata,
    input  ramRdata
  );

  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWdata,
    input  cpuRdata, cpuAck, cpuWait,
    output vidReq, vidAddr,
    input  vidRdata, vidAck,
    input  ramCs, ramWe, ramAddr, ramWdata,
    output ramRdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video fetches have priority, but the CPU is
// guaranteed a grant after STARVE_LIMIT consecutive video grants while it waits.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam int unsigned SKIP_W = 4;
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  localparam logic OWN_VID = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  logic [1:0]        state_q,     state_d;
  logic              owner_q,     owner_d;
  logic [SKIP_W-1:0] skip_q,      skip_d;
  logic              ram_cs_q,    ram_cs_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_ack_q,   cpu_ack_d;
  logic              vid_ack_q,   vid_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

  logic cpu_win_c;

  // CPU wins when video is idle or when video has starved it long enough
  assign cpu_win_c = bus.cpuReq && (!bus.vidReq || (skip_q == SKIP_MAX));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    skip_d      = skip_q;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_win_c) begin
          owner_d     = OWN_CPU;
          ram_cs_d    = 1'b1;
          ram_we_d    = bus.cpuWe;
          ram_addr_d  = bus.cpuAddr;
          ram_wdata_d = bus.cpuWdata;
          skip_d      = '0;
          state_d     = S_ACCESS;
        end else if (bus.vidReq) begin
          owner_d    = OWN_VID;
          ram_cs_d   = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = bus.vidAddr;
          if (bus.cpuReq && (skip_q != SKIP_MAX)) begin
            skip_d = skip_q + SKIP_W'(1);
          end
          state_d    = S_ACCESS;
        end
      end

      // Writes complete without a capture cycle
      S_ACCESS: begin
        if (ram_we_q) begin
          cpu_ack_d = (owner_q == OWN_CPU);
          vid_ack_d = (owner_q == OWN_VID);
          state_d   = S_ACK;
        end else begin
          state_d   = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = bus.ramRdata;
          cpu_ack_d   = 1'b1;
        end else begin
          vid_rdata_d = bus.ramRdata;
          vid_ack_d   = 1'b1;
        end
        state_d = S_ACK;
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_VID;
      skip_q      <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      skip_q      <= skip_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign bus.ramCs    = ram_cs_q;
  assign bus.ramWe    = ram_we_q;
  assign bus.ramAddr  = ram_addr_q;
  assign bus.ramWdata = ram_wdata_q;
  assign bus.cpuAck   = cpu_ack_q;
  assign bus.vidAck   = vid_ack_q;
  assign bus.cpuRdata = cpu_rdata_q;
  assign bus.vidRdata = vid_rdata_q;
  assign bus.cpuWait  = bus.cpuReq & ~cpu_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: agents push expected completions, a
// negedge monitor pops them on every ack and checks the RAM access behind it.
module tb_vram_arbiter;
  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned STARVE_LIMIT = 3;
  localparam int unsigned DEPTH        = 1 << ADDR_W;
  localparam int          TMO          = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  int   checks   = 0;
  int   failures = 0;
  txn_t exp_cpu[$];
  txn_t exp_vid[$];
  bit   exp_order[$];   // 1 = CPU ack expected next, 0 = video
  logic [DATA_W-1:0] ref_mem [int];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Power-up contents of the video RAM
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(32'(a) * 37 + 11);
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  // Synchronous RAM model
  logic [DATA_W-1:0] wmem [DEPTH];
  bit                wval [DEPTH];
  always @(posedge clk) begin
    if (bus.ramCs) begin
      if (bus.ramWe) begin
        wmem[bus.ramAddr] <= bus.ramWdata;
        wval[bus.ramAddr] <= 1'b1;
      end
      bus.ramRdata <= wval[bus.ramAddr] ? wmem[bus.ramAddr] : pat(bus.ramAddr);
    end
  end

  // Monitor / scoreboard
  int                cyc = 0;
  int                acc_cyc = 0;
  bit                acc_we = 1'b0;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic [DATA_W-1:0] acc_wdata = '0;
  bit                prev_cs = 1'b0;
  logic [DATA_W-1:0] hold_cpu = '0;
  logic [DATA_W-1:0] hold_vid = '0;

  task automatic check_ack(input bit is_cpu);
    txn_t t;
    int   lat;
    if (exp_order.size() > 0) begin
      bit o;
      o = exp_order.pop_front();
      chk(o == is_cpu, "grant_order", 32'(is_cpu), 32'(o));
    end
    if (is_cpu ? (exp_cpu.size() == 0) : (exp_vid.size() == 0)) begin
      chk(1'b0, is_cpu ? "cpu_spurious_ack" : "vid_spurious_ack", 32'd1, 32'd0);
      return;
    end
    t   = is_cpu ? exp_cpu.pop_front() : exp_vid.pop_front();
    lat = t.we ? 1 : 2;
    chk(acc_addr == t.addr, is_cpu ? "cpu_ram_addr" : "vid_ram_addr", 32'(acc_addr), 32'(t.addr));
    chk(acc_we == t.we, is_cpu ? "cpu_ram_we" : "vid_ram_we", 32'(acc_we), 32'(t.we));
    chk((cyc - acc_cyc) == lat, is_cpu ? "cpu_ack_latency" : "vid_ack_latency",
        32'(cyc - acc_cyc), 32'(lat));
    if (t.we) begin
      chk(acc_wdata == t.data, "cpu_ram_wdata", 32'(acc_wdata), 32'(t.data));
    end else if (is_cpu) begin
      chk(bus.cpuRdata == t.data, "cpu_rdata", 32'(bus.cpuRdata), 32'(t.data));
      hold_cpu = t.data;
    end else begin
      chk(bus.vidRdata == t.data, "vid_rdata", 32'(bus.vidRdata), 32'(t.data));
      hold_vid = t.data;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_cpu = '0;
        hold_vid = '0;
        prev_cs  = 1'b0;
      end else begin
        cyc++;
        chk(bus.cpuWait == (bus.cpuReq & ~bus.cpuAck), "cpuWait",
            32'(bus.cpuWait), 32'(bus.cpuReq & ~bus.cpuAck));
        if (bus.cpuAck && bus.vidAck) chk(1'b0, "ack_overlap", 32'd1, 32'd0);
        if (bus.ramWe && !bus.ramCs) chk(1'b0, "ramWe_without_ramCs", 32'd1, 32'd0);
        if (bus.ramCs && prev_cs) chk(1'b0, "ramCs_two_cycles", 32'd1, 32'd0);
        prev_cs = bus.ramCs;
        if (bus.ramCs) begin
          acc_cyc   = cyc;
          acc_we    = bus.ramWe;
          acc_addr  = bus.ramAddr;
          acc_wdata = bus.ramWdata;
        end
        if (bus.cpuAck) check_ack(1'b1);
        if (bus.vidAck) check_ack(1'b0);
        if (bus.cpuRdata != hold_cpu) chk(1'b0, "cpu_rdata_hold", 32'(bus.cpuRdata), 32'(hold_cpu));
        if (bus.vidRdata != hold_vid) chk(1'b0, "vid_rdata_hold", 32'(bus.vidRdata), 32'(hold_vid));
      end
    end
  end

  // Agents: called aligned at posedge+1; return at posedge+1 of the idle cycle, request still high
  task automatic cpu_txn(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit drop_early);
    txn_t t;
    bit   got = 1'b0;
    bit   dropped = 1'b0;
    t.we   = we;
    t.addr = a;
    t.data = we ? d : ref_rd(a);
    if (we) ref_mem[int'(a)] = d;
    exp_cpu.push_back(t);
    bus.cpuWe    = we;
    bus.cpuAddr  = a;
    bus.cpuWdata = d;
    bus.cpuReq   = 1'b1;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (bus.cpuAck) got = 1'b1;
      if (drop_early && !dropped && bus.ramCs && bus.ramAddr == a && bus.ramWe == we) begin
        #1;
        bus.cpuReq   = 1'b0;
        bus.cpuWe    = ~we;
        bus.cpuAddr  = ~a;
        bus.cpuWdata = ~d;
        dropped      = 1'b1;
      end
    end
    if (!got) chk(1'b0, "cpu_ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic vid_txn(input logic [ADDR_W-1:0] a);
    txn_t t;
    bit   got = 1'b0;
    bit   scr = 1'b0;
    t.we   = 1'b0;
    t.addr = a;
    t.data = ref_rd(a);
    exp_vid.push_back(t);
    bus.vidAddr = a;
    bus.vidReq  = 1'b1;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (bus.vidAck) got = 1'b1;
      if (!scr && bus.ramCs && !bus.ramWe && bus.ramAddr == a) begin
        #1;
        bus.vidAddr = ~a;
        scr = 1'b1;
      end
    end
    if (!got) chk(1'b0, "vid_ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk(bus.ramCs == 1'b0,   {tag, "_ramCs"},    32'(bus.ramCs),    32'd0);
    chk(bus.ramWe == 1'b0,   {tag, "_ramWe"},    32'(bus.ramWe),    32'd0);
    chk(bus.ramAddr == '0,   {tag, "_ramAddr"},  32'(bus.ramAddr),  32'd0);
    chk(bus.ramWdata == '0,  {tag, "_ramWdata"}, 32'(bus.ramWdata), 32'd0);
    chk(bus.cpuAck == 1'b0,  {tag, "_cpuAck"},   32'(bus.cpuAck),   32'd0);
    chk(bus.vidAck == 1'b0,  {tag, "_vidAck"},   32'(bus.vidAck),   32'd0);
    chk(bus.cpuRdata == '0,  {tag, "_cpuRdata"}, 32'(bus.cpuRdata), 32'd0);
    chk(bus.vidRdata == '0,  {tag, "_vidRdata"}, 32'(bus.vidRdata), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got 0x0 expected 0x1");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    reset        = 1'b1;
    bus.cpuReq   = 1'b0;
    bus.cpuWe    = 1'b0;
    bus.cpuAddr  = '0;
    bus.cpuWdata = '0;
    bus.vidReq   = 1'b0;
    bus.vidAddr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // No requests: RAM stays deselected
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk(bus.ramCs == 1'b0, "idle_ramCs", 32'(bus.ramCs), 32'd0);
    end
    @(posedge clk);
    #1;

    // CPU write then read back
    cpu_txn(1'b1, 11'h123, 8'h5A, 1'b0);
    bus.cpuReq = 1'b0;
    @(posedge clk);
    #1;
    cpu_txn(1'b0, 11'h123, 8'h00, 1'b0);
    bus.cpuReq = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous requests, no starvation history: video first
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b1);
    fork
      begin vid_txn(11'h000); bus.vidReq = 1'b0; end
      begin cpu_txn(1'b0, 11'h7FF, 8'h00, 1'b0); bus.cpuReq = 1'b0; end
    join
    @(posedge clk);
    #1;

    // CPU request dropped during ACCESS still completes once
    cpu_txn(1'b1, 11'h456, 8'hC3, 1'b1);
    bus.cpuReq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(bus.ramCs == 1'b0, "no_regrant_ramCs", 32'(bus.ramCs), 32'd0);
    end
    @(posedge clk);
    #1;
    cpu_txn(1'b0, 11'h456, 8'h00, 1'b0);
    bus.cpuReq = 1'b0;
    @(posedge clk);
    #1;

    // Continuous contention: V,V,V,C,V,V,V,C
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < int'(STARVE_LIMIT); j++) exp_order.push_back(1'b0);
      exp_order.push_back(1'b1);
    end
    fork
      begin
        for (int i = 0; i < 2 * int'(STARVE_LIMIT); i++) vid_txn(ADDR_W'($urandom_range(0, 32'h3FF)));
        bus.vidReq = 1'b0;
      end
      begin
        for (int i = 0; i < 2; i++) cpu_txn(1'b0, ADDR_W'(32'h400 + $urandom_range(0, 15)), 8'h00, 1'b0);
        bus.cpuReq = 1'b0;
      end
    join
    chk(exp_order.size() == 0, "order_drained", 32'(exp_order.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset during CAPTURE of a video read
    begin
      txn_t t;
      t.we = 1'b0; t.addr = 11'h055; t.data = ref_rd(11'h055);
      exp_vid.push_back(t);
      bus.vidAddr = 11'h055;
      bus.vidReq  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < TMO && !got; i++) begin
        @(negedge clk);
        if (bus.ramCs) got = 1'b1;
      end
      if (!got) chk(1'b0, "rst_grant_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_zero("midrst");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      got = 1'b0;
      for (int i = 0; i < TMO && !got; i++) begin
        @(negedge clk);
        if (bus.vidAck) got = 1'b1;
      end
      if (!got) chk(1'b0, "rst_vid_ack_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 bus.vidReq = 1'b0;
      @(posedge clk);
      #1;
    end

    // Randomised concurrent traffic
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          vid_txn(ADDR_W'($urandom_range(0, 32'h3FF)));
          if ($urandom_range(0, 1) == 1) begin
            bus.vidReq = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        bus.vidReq = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          cpu_txn(1'($urandom_range(0, 1)), ADDR_W'(32'h400 + $urandom_range(0, 15)),
                  DATA_W'($urandom), 1'b0);
          if ($urandom_range(0, 1) == 1) begin
            bus.cpuReq = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        bus.cpuReq = 1'b0;
      end
    join

    repeat (8) @(posedge clk);
    #1;
    chk(exp_cpu.size() == 0, "cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    chk(exp_vid.size() == 0, "vid_queue_drained", 32'(exp_vid.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
